godai_mem_arbiter: RTL
======================

// Module: godai_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the core's instruction and data interfaces (req/gnt/rvalid protocol).
//  Sits between riscv_core and the unified memory inside the Godai top level.
//  Grants one request per cycle, records the owner of every granted transaction,
//  and routes in-order responses back to the correct requester.
//  Data has priority; a streak limit prevents instruction-fetch starvation.
// PARAMETERS
//  ADDR_WIDTH      32  address width, both ports and memory side
//  DATA_WIDTH      32  data width, both ports and memory side
//  MAX_OUTSTANDING 4   granted-but-unanswered transactions tracked (power of 2, >=2)
//  DATA_STREAK     4   consecutive data grants allowed while instr_req_i is pending
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  instr_req_i    in   1   instruction request, held until granted
//  instr_gnt_o    out  1   instruction request accepted this cycle
//  instr_rvalid_o out  1   instruction read data valid
//  instr_addr_i   in   AW  instruction address
//  instr_rdata_o  out  DW  instruction read data
//  data_req_i     in   1   data request, held until granted
//  data_gnt_o     out  1   data request accepted this cycle
//  data_rvalid_o  out  1   data response valid (loads and stores)
//  data_we_i      in   1   1 = write
//  data_be_i      in   4   byte enables
//  data_addr_i    in   AW  data address
//  data_wdata_i   in   DW  write data
//  data_rdata_o   out  DW  load data
//  data_err_o     out  1   error flag for the data response
//  mem_req_o      out  1   memory request
//  mem_gnt_i      in   1   memory accepted request
//  mem_rvalid_i   in   1   memory response valid (in order)
//  mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o  out  1/4/AW/DW  muxed request fields
//  mem_rdata_i    in   DW  memory read data
//  mem_err_i      in   1   memory error, qualified by mem_rvalid_i
//  instr_err_o    out  1   sticky: error or unowned response seen on the instruction path
// BEHAVIOUR
//  Reset: FIFO empty, lock cleared, streak=0, instr_err_o=0. All gnt/rvalid/req outputs are 0 while rst_n is low.
//  Arbitration (combinational, per cycle):
//   - Locked: the locked owner is selected.
//   - Both requesting: data wins unless streak==DATA_STREAK, in which case instr wins.
//   - One requesting: that requester is selected.
//  mem_req_o = (instr_req_i|data_req_i) & !fifo_full; request fields are muxed from the selected port
//  (mem_we_o=0 and mem_be_o=4'hF when instr is selected).
//  <sel>_gnt_o = mem_gnt_i & mem_req_o & selected; never both in one cycle; zero-cycle pass-through.
//  Lock: set when mem_req_o=1 and mem_gnt_i=0; it holds the owner (and thus the fields) stable until the grant.
//  Streak: +1 on a data grant while instr_req_i=1; cleared on an instr grant or when instr_req_i=0; saturates.
//  Owner FIFO (depth MAX_OUTSTANDING): push owner on each grant, pop on each mem_rvalid_i.
//   - Push and pop in the same cycle are both allowed, including when full or empty.
//   - When full: mem_req_o=0, except that a pop in that cycle does not free a slot for that cycle.
//  Response routing: same cycle as mem_rvalid_i, to the head owner.
//   - rdata is muxed to the owner; the other rvalid stays 0.
//   - data_err_o = mem_err_i when the owner is data, else 0.
//   - mem_err_i with owner instr sets instr_err_o.
//   - mem_rvalid_i with an empty FIFO: the response is dropped and instr_err_o is set.
//  Read/write pointers wrap modulo MAX_OUTSTANDING; an extra count bit distinguishes full from empty.
//  Reset mid-operation clears all in-flight state; late memory responses are then treated as unowned (above).
// STRUCTURE
//  godai_arb_pkg: owner_e {OWNER_INSTR=1'b0, OWNER_DATA=1'b1}; localparam PTR_W=$clog2(MAX_OUTSTANDING).
//  Sub-module godai_owner_fifo: sync FIFO of owner_e with push/pop/full/empty/head.
//  Top level holds the arbitration, lock, streak and routing logic.
// TESTING
//  1. Instr-only stream, mem_gnt_i=1, rvalid 1 cycle later: 8 fetches granted back-to-back, rdata to instr only.
//  2. Both requesting continuously, DATA_STREAK=4: grant order D,D,D,D,I,D,D,D,D,I...
//  3. mem_gnt_i=0 for 3 cycles while instr is selected, then data_req_i rises: instr stays selected and is granted first.
//  4. 4 grants with no rvalid: mem_req_o drops on the 5th cycle; rvalid+pending req in one cycle -> no grant that
//     cycle, grant the next.
//  5. Interleaved I,D,I grants; rvalids carry mem_err_i=1 on the 2nd and 3rd: data_err_o=1 on the 2nd, instr_err_o set
//     after the 3rd.
//  6. rst_n pulsed low with 3 outstanding, then a mem_rvalid_i arrives: no rvalid output, FIFO empty, instr_err_o=1.

Source files
------------

// File: rtl/godai_arb_pkg.sv
// Shared types and defaults for the Godai instruction/data memory arbiter.
package godai_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned PTR_W               = $clog2(DEF_MAX_OUTSTANDING);
    localparam int unsigned BE_W                = 4;

    // Instruction fetches are always full-word reads.
    localparam logic [BE_W-1:0] BE_FULL = '1;

endpackage

// File: rtl/godai_owner_fifo.sv
// In-order record of which requester owns each granted memory transaction.
module godai_owner_fifo
    import godai_arb_pkg::*;
#(
    parameter int unsigned PTR_BITS = PTR_W
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int unsigned DEPTH = 1 << PTR_BITS;
    localparam int unsigned CNT_W = PTR_BITS + 1;

    logic [CNT_W-1:0] wptr_q;
    logic [CNT_W-1:0] rptr_q;
    owner_e           slot_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    // The extra pointer bit separates a wrapped (full) FIFO from an empty one.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_BITS] != rptr_q[PTR_BITS]) &&
                     (wptr_q[PTR_BITS-1:0] == rptr_q[PTR_BITS-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = slot_q[rptr_q[PTR_BITS-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= OWNER_INSTR;
            end
        end else begin
            if (push_en) begin
                slot_q[wptr_q[PTR_BITS-1:0]] <= push_owner;
                wptr_q <= wptr_q + CNT_W'(1);
            end
            if (pop_en) begin
                rptr_q <= rptr_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/godai_mem_arbiter.sv
// Shares one single-port memory between the core's instruction and data ports,
// granting one request per cycle and routing in-order responses to their owner.
module godai_mem_arbiter
    import godai_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned DATA_STREAK     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [BE_W-1:0]       data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_we_o,
    output logic [BE_W-1:0]       mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);

    localparam int unsigned FIFO_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned STREAK_W   = $clog2(DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);

    logic                lock_q;
    owner_e              lock_owner_q;
    logic [STREAK_W-1:0] streak_q;
    logic                instr_err_q;

    owner_e sel;
    logic   grant;
    logic   fifo_full;
    logic   fifo_empty;
    owner_e head_owner;
    logic   rsp_owned;

    // Owner selection: a pending ungranted request keeps its owner; otherwise data
    // wins unless it has already taken DATA_STREAK grants past a waiting fetch.
    always_comb begin
        sel = OWNER_INSTR;
        if (lock_q) begin
            sel = lock_owner_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (streak_q == STREAK_MAX) ? OWNER_INSTR : OWNER_DATA;
        end else if (data_req_i) begin
            sel = OWNER_DATA;
        end
    end

    assign mem_req_o   = rst_n && (instr_req_i || data_req_i) && !fifo_full;
    assign grant       = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = grant && (sel == OWNER_INSTR);
    assign data_gnt_o  = grant && (sel == OWNER_DATA);

    assign mem_we_o    = (sel == OWNER_DATA) && data_we_i;
    assign mem_be_o    = (sel == OWNER_DATA) ? data_be_i    : BE_FULL;
    assign mem_addr_o  = (sel == OWNER_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel == OWNER_DATA) ? data_wdata_i : '0;

    godai_owner_fifo #(
        .PTR_BITS (FIFO_PTR_W)
    ) u_owner_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (grant),
        .push_owner (sel),
        .pop        (mem_rvalid_i),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head_owner)
    );

    // Responses are steered to the oldest outstanding owner; unowned ones are dropped.
    assign rsp_owned      = rst_n && mem_rvalid_i && !fifo_empty;
    assign instr_rvalid_o = rsp_owned && (head_owner == OWNER_INSTR);
    assign data_rvalid_o  = rsp_owned && (head_owner == OWNER_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_err_o    = instr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
            streak_q     <= '0;
            instr_err_q  <= 1'b0;
        end else begin
            if (mem_req_o && !mem_gnt_i) begin
                lock_q       <= 1'b1;
                lock_owner_q <= sel;
            end else if (grant) begin
                lock_q <= 1'b0;
            end

            // Count data grants that bypass a waiting fetch, saturating at the limit.
            if (!instr_req_i || instr_gnt_o) begin
                streak_q <= '0;
            end else if (data_gnt_o && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + STREAK_W'(1);
            end

            if ((mem_rvalid_i && fifo_empty) || (instr_rvalid_o && mem_err_i)) begin
                instr_err_q <= 1'b1;
            end
        end
    end

endmodule
